// File: rtl/call_return_ctrl.sv
// CALL/RET sequencer: drives push/pop strobes to an external return-address stack
// and redirects the PC on CALL (to the target) and RET (to the popped address).
module call_return_ctrl #(
  parameter int unsigned WIDTH_DATA = 32,
  parameter int unsigned DEPTH      = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call,
  input  logic                  ret,
  input  logic [WIDTH_DATA-1:0] pc_in,
  input  logic [WIDTH_DATA-1:0] call_target,
  input  logic                  err_clear,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [WIDTH_DATA-1:0] stk_wdata,
  input  logic [WIDTH_DATA-1:0] stk_rdata,
  input  logic                  stk_full,
  input  logic                  stk_empty,
  output logic                  pc_load,
  output logic [WIDTH_DATA-1:0] pc_next,
  output logic                  busy,
  output logic                  overflow_err,
  output logic                  underflow_err,
  output logic [DEPTH-1:0]      depth
);

  typedef enum logic [1:0] {StIdle, StPush, StPop, StLoad} state_e;

  state_e                state_q, state_d;
  logic [WIDTH_DATA-1:0] ret_addr_q, ret_addr_d;
  logic [WIDTH_DATA-1:0] target_q, target_d;
  logic [DEPTH-1:0]      depth_q, depth_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  ovf_set, unf_set;

  always_comb begin
    state_d    = state_q;
    ret_addr_d = ret_addr_q;
    target_d   = target_q;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    case (state_q)
      StIdle: begin
        // CALL wins over a simultaneous RET; the RET is simply dropped.
        if (call) begin
          if (!stk_full) begin
            state_d    = StPush;
            ret_addr_d = pc_in + WIDTH_DATA'(1);
            target_d   = call_target;
          end else begin
            ovf_set = 1'b1;
          end
        end else if (ret) begin
          if (!stk_empty) state_d = StPop;
          else            unf_set = 1'b1;
        end
      end
      StPush:  state_d = StIdle;
      StPop:   state_d = StLoad;
      StLoad:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Depth moves on the edge that enters PUSH/POP so it already reflects the
  // strobe during the strobe cycle.
  always_comb begin
    depth_d = depth_q;
    if (state_q == StIdle && state_d == StPush && depth_q != '1) begin
      depth_d = depth_q + DEPTH'(1);
    end else if (state_q == StIdle && state_d == StPop && depth_q != '0) begin
      depth_d = depth_q - DEPTH'(1);
    end
  end

  // A new error in the same cycle as err_clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_set ? 1'b1 : (err_clear ? 1'b0 : ovf_q);
    unf_d = unf_set ? 1'b1 : (err_clear ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ret_addr_q <= '0;
      target_q   <= '0;
      depth_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_addr_q <= ret_addr_d;
      target_q   <= target_d;
      depth_q    <= depth_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign stk_push      = (state_q == StPush);
  assign stk_pop       = (state_q == StPop);
  assign pc_load       = (state_q == StPush) || (state_q == StLoad);
  assign busy          = (state_q != StIdle);
  assign stk_wdata     = ret_addr_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
  assign depth         = depth_q;

  always_comb begin
    pc_next = '0;
    case (state_q)
      StPush:  pc_next = target_q;
      StLoad:  pc_next = stk_rdata;
      default: pc_next = '0;
    endcase
  end

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed vector bench for call_return_ctrl: table of per-cycle stimulus and
// expected outputs, plus hand sequences for reset aborts and depth saturation.
module tb_call_return_ctrl;

  logic        clk = 1'b0;
  logic        reset, call, ret, err_clear, stk_full, stk_empty;
  logic [31:0] pc_in, call_target, stk_rdata;
  logic        stk_push, stk_pop, pc_load, busy, overflow_err, underflow_err;
  logic [31:0] stk_wdata, pc_next;
  logic [9:0]  depth;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  call_return_ctrl #(.WIDTH_DATA(32), .DEPTH(10)) dut (
    .clk(clk), .reset(reset), .call(call), .ret(ret), .pc_in(pc_in),
    .call_target(call_target), .err_clear(err_clear), .stk_push(stk_push),
    .stk_pop(stk_pop), .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
    .stk_full(stk_full), .stk_empty(stk_empty), .pc_load(pc_load), .pc_next(pc_next),
    .busy(busy), .overflow_err(overflow_err), .underflow_err(underflow_err), .depth(depth)
  );

  // ctl = {call, ret, err_clear, full, empty}; ectl = {push, pop, load, busy, ovf, unf}
  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] pc, tgt, rdata;
    logic [5:0]  ectl;
    logic [31:0] enext, ewdata;
    logic [9:0]  edepth;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    call = 0; ret = 0; err_clear = 0; stk_full = 0; stk_empty = 0;
    pc_in = 0; call_target = 0; stk_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  function automatic logic [31:0] ctl_now();
    return {26'b0, stk_push, stk_pop, pc_load, busy, overflow_err, underflow_err};
  endfunction

  initial begin
    //           ctl       pc            tgt       rdata     ectl       next      wdata     depth
    vecs[0]  = '{5'b00000, 32'h0,        32'h0,    32'h0,    6'b000000, 32'h0,    32'h0,    10'd0};
    vecs[1]  = '{5'b10001, 32'h100,      32'h400,  32'h0,    6'b101100, 32'h400,  32'h101,  10'd1};
    vecs[2]  = '{5'b00000, 32'h0,        32'h0,    32'h0,    6'b000000, 32'h0,    32'h101,  10'd1};
    vecs[3]  = '{5'b01000, 32'h0,        32'h0,    32'h0,    6'b010100, 32'h0,    32'h101,  10'd0};
    vecs[4]  = '{5'b00000, 32'h0,        32'h0,    32'h101,  6'b001100, 32'h101,  32'h101,  10'd0};
    vecs[5]  = '{5'b00000, 32'h0,        32'h0,    32'h101,  6'b000000, 32'h0,    32'h101,  10'd0};
    vecs[6]  = '{5'b01001, 32'h0,        32'h0,    32'h0,    6'b000001, 32'h0,    32'h101,  10'd0};
    vecs[7]  = '{5'b00100, 32'h0,        32'h0,    32'h0,    6'b000000, 32'h0,    32'h101,  10'd0};
    vecs[8]  = '{5'b10010, 32'h50,       32'h60,   32'h0,    6'b000010, 32'h0,    32'h101,  10'd0};
    vecs[9]  = '{5'b10110, 32'h50,       32'h60,   32'h0,    6'b000010, 32'h0,    32'h101,  10'd0};
    vecs[10] = '{5'b00100, 32'h0,        32'h0,    32'h0,    6'b000000, 32'h0,    32'h101,  10'd0};
    vecs[11] = '{5'b11000, 32'h1ff,      32'h20,   32'h0,    6'b101100, 32'h20,   32'h200,  10'd1};
    vecs[12] = '{5'b01000, 32'h0,        32'h0,    32'h0,    6'b000000, 32'h0,    32'h200,  10'd1};
    vecs[13] = '{5'b00000, 32'h0,        32'h0,    32'h0,    6'b000000, 32'h0,    32'h200,  10'd1};
    vecs[14] = '{5'b10000, 32'hffffffff, 32'h8,    32'h0,    6'b101100, 32'h8,    32'h0,    10'd2};
    vecs[15] = '{5'b11000, 32'h0,        32'h0,    32'h0,    6'b000000, 32'h0,    32'h0,    10'd2};
    vecs[16] = '{5'b01001, 32'h0,        32'h0,    32'h0,    6'b000001, 32'h0,    32'h0,    10'd2};

    reset = 1;
    idle_inputs();
    step();
    chk("reset ctl", ctl_now(), 32'h0);
    chk("reset wdata", stk_wdata, 32'h0);
    chk("reset pc_next", pc_next, 32'h0);
    chk("reset depth", 32'(depth), 32'h0);
    reset = 0;

    for (int i = 0; i < 17; i++) begin
      {call, ret, err_clear, stk_full, stk_empty} = vecs[i].ctl;
      pc_in       = vecs[i].pc;
      call_target = vecs[i].tgt;
      stk_rdata   = vecs[i].rdata;
      step();
      chk($sformatf("v%0d ctl", i), ctl_now(), 32'(vecs[i].ectl));
      chk($sformatf("v%0d pc_next", i), pc_next, vecs[i].enext);
      chk($sformatf("v%0d wdata", i), stk_wdata, vecs[i].ewdata);
      chk($sformatf("v%0d depth", i), 32'(depth), 32'(vecs[i].edepth));
    end

    // Reset during POP aborts the RET: no load the following cycle.
    do_reset();
    call = 1; pc_in = 32'h10; call_target = 32'h40;
    step();
    call = 0; idle_inputs();
    step();
    ret = 1;
    step();
    chk("pre-abort pop", 32'(stk_pop), 32'h1);
    ret = 0; reset = 1; stk_rdata = 32'h555;
    step();
    chk("pop abort ctl", ctl_now(), 32'h0);
    chk("pop abort pc_next", pc_next, 32'h0);
    chk("pop abort depth", 32'(depth), 32'h0);
    reset = 0;
    step();
    chk("pop abort after", ctl_now(), 32'h0);

    // Reset during PUSH, and reset overriding a call.
    call = 1; pc_in = 32'h20; call_target = 32'h80;
    step();
    chk("pre-abort push", ctl_now(), 32'h2c);
    call = 0; reset = 1;
    step();
    chk("push abort ctl", ctl_now(), 32'h0);
    chk("push abort wdata", stk_wdata, 32'h0);
    call = 1; err_clear = 1; stk_full = 1;
    step();
    chk("reset beats call", ctl_now(), 32'h0);
    reset = 0; idle_inputs();

    // Depth saturates at zero on a pop it did not push.
    ret = 1;
    step();
    chk("depth sat 0 pop", 32'(stk_pop), 32'h1);
    chk("depth sat 0", 32'(depth), 32'h0);
    ret = 0;
    step();
    step();

    // Depth saturates at all-ones.
    for (int i = 0; i < 1025; i++) begin
      call = 1; pc_in = 32'(i);
      step();
      call = 0;
      step();
    end
    chk("depth sat max", 32'(depth), 32'h3ff);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
